// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-to-memory wait-state bridge.
package mem_bridge_pkg;

  // Bridge FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR      = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Memory read latency (7 ns) spans three 2.5 ns clocks.
  localparam int          DEF_READ_WAIT  = 3;
  // 1024 words of byte-addressed memory.
  localparam logic [31:0] DEF_ADDR_LIMIT = 32'h0000_1000;

endpackage

// File: rtl/mem_wait_bridge.sv
// Bridge between the multi-cycle CPU and the asynchronous word memory.
// Handshake: a request transfers on a rising edge where cpu_req_valid and
// cpu_req_ready are both 1; cpu_req_ready is 1 only in IDLE, and request
// inputs are ignored otherwise. The response is a single-cycle
// cpu_resp_valid pulse with no backpressure. Every output is registered.
module mem_wait_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          READ_WAIT  = DEF_READ_WAIT,
  parameter logic [31:0] ADDR_LIMIT = DEF_ADDR_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_write,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  output logic        cpu_resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output state_t      dbg_state
);

  localparam int CW = $clog2(READ_WAIT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_d, resp_valid_d, err_d, rd_d, wr_d;
  logic [31:0]   rdata_d, addr_d, wdata_d;
  logic          req_bad;

  // Misaligned or beyond the last word.
  assign req_bad   = (cpu_req_addr[1:0] != 2'b00) || (cpu_req_addr >= ADDR_LIMIT);
  assign dbg_state = state_q;

  // Next-state and next-output logic; holds everything not explicitly changed.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = cpu_req_ready;
    resp_valid_d = 1'b0;
    err_d        = cpu_resp_err;
    rdata_d      = cpu_resp_rdata;
    rd_d         = mem_read;
    wr_d         = mem_write;
    addr_d       = mem_address;
    wdata_d      = mem_write_data;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          addr_d  = cpu_req_addr;
          wdata_d = cpu_req_wdata;
          ready_d = 1'b0;
          if (req_bad) begin
            // Illegal request: answer immediately, never touch memory.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = 32'd0;
          end else if (cpu_req_write) begin
            state_d = ST_WR;
            wr_d    = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
            rd_d    = 1'b1;
            cnt_d   = CW'(READ_WAIT - 1);
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          // Read data has settled after READ_WAIT cycles of mem_read.
          rdata_d      = mem_read_data;
          rd_d         = 1'b0;
          err_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WR: begin
        // Memory captures the write at this edge; one-cycle strobe.
        wr_d         = 1'b0;
        err_d        = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_resp_err   <= 1'b0;
      cpu_resp_rdata <= 32'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cpu_req_ready  <= ready_d;
      cpu_resp_valid <= resp_valid_d;
      cpu_resp_err   <= err_d;
      cpu_resp_rdata <= rdata_d;
      mem_read       <= rd_d;
      mem_write      <= wr_d;
      mem_address    <= addr_d;
      mem_write_data <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench: three bridges with READ_WAIT = 1, 3, 5 on shared clock/reset,
// each attached to its own word memory model.
module tb_mem_wait_bridge;
  import mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid      [3];
  logic        req_write      [3];
  logic [31:0] req_addr       [3];
  logic [31:0] req_wdata      [3];
  logic        req_ready      [3];
  logic        resp_valid     [3];
  logic [31:0] resp_rdata     [3];
  logic        resp_err       [3];
  logic        mem_read       [3];
  logic        mem_write      [3];
  logic [31:0] mem_address    [3];
  logic [31:0] mem_write_data [3];
  logic [31:0] mem_read_data  [3];
  state_t      dbg_state      [3];
  logic [31:0] mem [3][1024];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_wait_bridge #(
      .READ_WAIT ((g == 0) ? 1 : ((g == 1) ? 3 : 5)),
      .ADDR_LIMIT(32'h0000_1000)
    ) u_dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_req_valid (req_valid[g]),
      .cpu_req_ready (req_ready[g]),
      .cpu_req_write (req_write[g]),
      .cpu_req_addr  (req_addr[g]),
      .cpu_req_wdata (req_wdata[g]),
      .cpu_resp_valid(resp_valid[g]),
      .cpu_resp_rdata(resp_rdata[g]),
      .cpu_resp_err  (resp_err[g]),
      .mem_read      (mem_read[g]),
      .mem_write     (mem_write[g]),
      .mem_address   (mem_address[g]),
      .mem_write_data(mem_write_data[g]),
      .mem_read_data (mem_read_data[g]),
      .dbg_state     (dbg_state[g])
    );
  end

  // Memory model: asynchronous read, write on posedge; reloaded on reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 1024; i++) mem[k][i] <= 32'd0;
        mem[k][12] <= 32'hDEAD_BEEF;
      end
    end else begin
      for (int k = 0; k < 3; k++)
        if (mem_write[k]) mem[k][mem_address[k][11:2]] <= mem_write_data[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) mem_read_data[k] = mem[k][mem_address[k][11:2]];
  end

  function automatic int rw_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Driver: one request on bridge k, checked cycle by cycle from E0.
  // Request lines are scrambled while busy to show they are ignored.
  task automatic do_req(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
    int   lat;
    logic ok;
    ok  = (addr[1:0] == 2'b00) && (addr < 32'h0000_1000);
    lat = !ok ? 0 : (wr ? 1 : rw_of(k));
    @(negedge clk);
    check($sformatf("%s%0d.ready_in", tag, k), 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(posedge clk);
    for (int i = 0; i <= lat + 1; i++) begin
      @(negedge clk);
      if (i < lat) begin
        req_write[k] = ~wr;
        req_addr[k]  = 32'h0000_03FC;
        req_wdata[k] = 32'hBAD0_BAD0;
      end else begin
        req_valid[k] = 1'b0;
      end
      check($sformatf("%s%0d.resp_valid@%0d", tag, k, i), 32'(resp_valid[k]), 32'(i == lat));
      check($sformatf("%s%0d.mem_read@%0d", tag, k, i), 32'(mem_read[k]),
            32'(ok && !wr && i < lat));
      check($sformatf("%s%0d.mem_write@%0d", tag, k, i), 32'(mem_write[k]),
            32'(ok && wr && i < lat));
      check($sformatf("%s%0d.ready@%0d", tag, k, i), 32'(req_ready[k]), 32'(i == lat + 1));
      if (ok && (i == 0 || i == lat)) begin
        check($sformatf("%s%0d.mem_address@%0d", tag, k, i), mem_address[k], addr);
        if (wr) check($sformatf("%s%0d.mem_wdata", tag, k), mem_write_data[k], wdata);
      end
      if (i == lat) begin
        check($sformatf("%s%0d.rdata", tag, k), resp_rdata[k], exp_rdata);
        check($sformatf("%s%0d.err", tag, k), 32'(resp_err[k]), 32'(exp_err));
      end
    end
  endtask

  initial begin
    logic        t_wr   [3];
    logic [31:0] t_addr [3];
    logic [31:0] t_wdata[3];
    int j, nresp;

    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'd0;
      req_wdata[k] = 32'd0;
    end

    // Reset values
    #12;
    check("rst.ready",      32'(req_ready[1]),  32'd1);
    check("rst.resp_valid", 32'(resp_valid[1]), 32'd0);
    check("rst.err",        32'(resp_err[1]),   32'd0);
    check("rst.mem_read",   32'(mem_read[1]),   32'd0);
    check("rst.mem_write",  32'(mem_write[1]),  32'd0);
    check("rst.rdata",      resp_rdata[1],      32'd0);
    check("rst.mem_address", mem_address[1],    32'd0);
    check("rst.mem_wdata",  mem_write_data[1],  32'd0);
    check("rst.state",      32'(dbg_state[1]),  32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    // Read, write, misaligned, out-of-range on each READ_WAIT variant
    for (int k = 0; k < 3; k++) begin
      do_req(k, 1'b0, 32'h30, 32'd0, 32'hDEAD_BEEF, 1'b0, "rd");
      do_req(k, 1'b1, 32'hC8, 32'd55, 32'hDEAD_BEEF, 1'b0, "wr");
      check($sformatf("wr%0d.mem50", k), mem[k][50], 32'd55);
      do_req(k, 1'b0, 32'h31, 32'd0, 32'd0, 1'b1, "mis");
      do_req(k, 1'b0, 32'h1000, 32'd0, 32'd0, 1'b1, "oor");
    end

    // Back-to-back read, write, read with valid held high (READ_WAIT=3)
    t_wr[0] = 1'b0; t_addr[0] = 32'h30; t_wdata[0] = 32'd0;
    t_wr[1] = 1'b1; t_addr[1] = 32'h40; t_wdata[1] = 32'h0000_1234;
    t_wr[2] = 1'b0; t_addr[2] = 32'h40; t_wdata[2] = 32'd0;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'h0000_1234);
    j = 0;
    nresp = 0;
    @(negedge clk);
    for (int c = 0; c < 60 && nresp < 3; c++) begin
      if (resp_valid[1]) begin
        check($sformatf("b2b.ready_busy%0d", nresp), 32'(req_ready[1]), 32'd0);
        if (exp_q.size() > 0)
          check($sformatf("b2b.rdata%0d", nresp), resp_rdata[1], exp_q.pop_front());
        check($sformatf("b2b.err%0d", nresp), 32'(resp_err[1]), 32'd0);
        nresp++;
      end
      if (req_ready[1] && j < 3) begin
        req_valid[1] = 1'b1;
        req_write[1] = t_wr[j];
        req_addr[1]  = t_addr[j];
        req_wdata[1] = t_wdata[j];
        j++;
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    check("b2b.responses", 32'(nresp), 32'd3);
    check("b2b.mem16", mem[1][16], 32'h0000_1234);
    repeat (2) @(negedge clk);

    // Reset two cycles into a read
    check("arst.ready_in", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = 32'h30;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("arst.mem_read_before", 32'(mem_read[1]), 32'd1);
    reset = 1'b0;
    #1;
    check("arst.mem_read", 32'(mem_read[1]), 32'd0);
    check("arst.ready",    32'(req_ready[1]), 32'd1);
    check("arst.state",    32'(dbg_state[1]), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("arst.resp_valid%0d", i), 32'(resp_valid[1]), 32'd0);
    end
    reset = 1'b1;
    do_req(1, 1'b0, 32'h30, 32'd0, 32'hDEAD_BEEF, 1'b0, "post");

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
